// File: rtl/mux_arb_4x1.sv
// Four-requester round-robin arbiter driving a registered 4:1 shared data channel.
// Optional per-owner hold limit is compiled in with `define MUX_ARB_HOLD_LIMIT_EN (limit set by HOLD_MAX).
module mux_arb_4x1 #(
   parameter int HOLD_MAX = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   input  logic [3:0] in_data,
   output logic [3:0] gnt,
   output logic [1:0] sel,
   output logic       y,
   output logic       valid
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t     state;
   logic [1:0] ptr;
   logic [3:0] pool;
   logic [1:0] win;

   if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_hold_max_illegal
      $error("mux_arb_4x1: HOLD_MAX must be within 1..255");
   end

`ifdef MUX_ARB_HOLD_LIMIT_EN
   localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);
   logic [7:0] cnt;
`endif

   // First requester set in pool, searching upward from start with wrap-around.
   function automatic logic [1:0] rr_pick(input logic [3:0] pool_in, input logic [1:0] start);
      logic [1:0] idx;
      logic [1:0] result;
      logic       found;
      result = start;
      found  = 1'b0;
      for (int k = 0; k < 4; k++) begin
         idx = start + 2'(k);
         if (!found && pool_in[idx]) begin
            result = idx;
            found  = 1'b1;
         end
      end
      return result;
   endfunction

   // Requesters eligible to take the channel at this edge; empty means no new grant.
   always_comb begin
      pool = 4'b0000;
      if (state == IDLE || !req[sel]) begin
         pool = req;
      end
`ifdef MUX_ARB_HOLD_LIMIT_EN
      else if (cnt == HOLD_LAST) begin
         pool = req & ~gnt;
      end
`endif
      win = rr_pick(pool, ptr);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         gnt   <= 4'b0000;
         sel   <= 2'b00;
         y     <= 1'b0;
         valid <= 1'b0;
         ptr   <= 2'b00;
`ifdef MUX_ARB_HOLD_LIMIT_EN
         cnt   <= 8'd0;
`endif
      end else begin
         if (state == GRANT && req[sel]) begin
            y     <= in_data[sel];
            valid <= 1'b1;
         end else begin
            valid <= 1'b0;
         end

         if (|pool) begin
            state <= GRANT;
            gnt   <= 4'b0001 << win;
            sel   <= win;
            ptr   <= win + 2'd1;
`ifdef MUX_ARB_HOLD_LIMIT_EN
            cnt   <= 8'd0;
`endif
         end else if (state == GRANT && !req[sel]) begin
            // sel deliberately keeps the last owner's index
            state <= IDLE;
            gnt   <= 4'b0000;
         end
`ifdef MUX_ARB_HOLD_LIMIT_EN
         else if (state == GRANT) begin
            cnt <= (cnt == HOLD_LAST) ? 8'd0 : cnt + 8'd1;
         end
`endif
      end
   end

endmodule

// File: tb/tb_mux_arb_4x1.sv
// Randomized bench for mux_arb_4x1 against an owner/tenure reference model, plus directed scenarios.
// Follows the DUT build: define MUX_ARB_HOLD_LIMIT_EN for both to exercise the hold limit (HOLD_MAX=4).
module tb_mux_arb_4x1;

   localparam int HOLD = 4;
`ifdef MUX_ARB_HOLD_LIMIT_EN
   localparam bit LIMIT = 1'b1;
`else
   localparam bit LIMIT = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] req;
   logic [3:0] in_data;
   logic [3:0] gnt;
   logic [1:0] sel;
   logic       y;
   logic       valid;

   int vectors = 0;
   int miscompares = 0;
   bit cmp_en = 1'b0;

   // Reference model state
   int   m_owner = -1;
   int   m_ptr = 0;
   int   m_tenure = 0;
   int   m_sel = 0;
   logic m_y = 1'b0;
   logic m_valid = 1'b0;

   mux_arb_4x1 #(.HOLD_MAX(HOLD)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .req(req),
      .in_data(in_data),
      .gnt(gnt),
      .sel(sel),
      .y(y),
      .valid(valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // Owner keeps the channel while requesting; must hand over when it drops,
   // or when it has held HOLD cycles and someone else is waiting.
   always @(posedge clk) begin
      bit others;
      bit found;
      bit must_pick;
      int w;
      int j;
      if (!rst_n) begin
         m_owner = -1; m_ptr = 0; m_tenure = 0; m_sel = 0; m_y = 1'b0; m_valid = 1'b0;
      end else begin
         if (m_owner >= 0 && req[m_owner]) begin
            m_y = in_data[m_owner];
            m_valid = 1'b1;
         end else begin
            m_valid = 1'b0;
         end
         others = 1'b0;
         for (int i = 0; i < 4; i++) if (i != m_owner && req[i]) others = 1'b1;
         must_pick = (m_owner < 0) || !req[m_owner] || (LIMIT && m_tenure >= HOLD && others);
         if (must_pick) begin
            found = 1'b0;
            w = 0;
            for (int k = 0; k < 4; k++) begin
               j = (m_ptr + k) % 4;
               if (!found && j != m_owner && req[j]) begin
                  found = 1'b1;
                  w = j;
               end
            end
            if (found) begin
               m_owner = w; m_sel = w; m_ptr = (w + 1) % 4; m_tenure = 1;
            end else begin
               m_owner = -1;
            end
         end else if (LIMIT && m_tenure >= HOLD) begin
            m_tenure = 1;
         end else begin
            m_tenure++;
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("gnt", 8'(gnt), (m_owner < 0) ? 8'h00 : 8'(1 << m_owner));
         chk("sel", 8'(sel), 8'(m_sel));
         chk("valid", 8'(valid), 8'(m_valid));
         chk("y", 8'(y), 8'(m_y));
      end
   end

   // Inputs change at the falling edge; outputs are checked one full rising edge later.
   task automatic tick(input logic [3:0] r, input logic [3:0] d, input logic rn);
      req = r;
      in_data = d;
      rst_n = rn;
      @(posedge clk);
      @(negedge clk);
   endtask

   logic [3:0] gseq [5];
   logic [3:0] r_rand;
   logic [3:0] exp_g;

   initial begin
      req = 4'b0000;
      in_data = 4'b0000;
      rst_n = 1'b0;
      tick(4'b0000, 4'b0000, 1'b0);
      cmp_en = 1'b1;
      tick(4'b0000, 4'b0000, 1'b0);
      chk("rst_gnt", 8'(gnt), 8'h00);
      chk("rst_sel", 8'(sel), 8'h00);
      chk("rst_valid", 8'(valid), 8'h00);
      chk("rst_y", 8'(y), 8'h00);

      // First grant and its data latency
      tick(4'b0101, 4'b0001, 1'b1);
      chk("first_gnt", 8'(gnt), 8'h01);
      chk("first_sel", 8'(sel), 8'h00);
      chk("first_valid", 8'(valid), 8'h00);
      tick(4'b0101, 4'b0001, 1'b1);
      chk("first_valid_n2", 8'(valid), 8'h01);
      chk("first_y_n2", 8'(y), 8'h01);

      // Handover with no idle bubble
      tick(4'b0100, 4'b0100, 1'b1);
      chk("handover_gnt", 8'(gnt), 8'h04);
      chk("handover_sel", 8'(sel), 8'h02);
      chk("handover_valid_gap", 8'(valid), 8'h00);
      tick(4'b0100, 4'b0100, 1'b1);
      chk("handover_valid", 8'(valid), 8'h01);
      chk("handover_y", 8'(y), 8'h01);
      tick(4'b0000, 4'b0000, 1'b1);
      chk("release_gnt", 8'(gnt), 8'h00);
      chk("release_sel_holds", 8'(sel), 8'h02);

      // Rotating order under full load
      tick(4'b0000, 4'b0000, 1'b0);
      tick(4'b1111, 4'b1010, 1'b1); gseq[0] = gnt;
      tick(4'b1110, 4'b1010, 1'b1); gseq[1] = gnt;
      tick(4'b1101, 4'b1010, 1'b1); gseq[2] = gnt;
      tick(4'b1011, 4'b1010, 1'b1); gseq[3] = gnt;
      tick(4'b0111, 4'b1010, 1'b1); gseq[4] = gnt;
      chk("rr_0", 8'(gseq[0]), 8'h01);
      chk("rr_1", 8'(gseq[1]), 8'h02);
      chk("rr_2", 8'(gseq[2]), 8'h04);
      chk("rr_3", 8'(gseq[3]), 8'h08);
      chk("rr_4", 8'(gseq[4]), 8'h01);

      // Reset during a grant to requester 3
      tick(4'b1000, 4'b1000, 1'b1);
      chk("own3_gnt", 8'(gnt), 8'h08);
      tick(4'b1000, 4'b1000, 1'b1);
      tick(4'b1000, 4'b1000, 1'b0);
      chk("midrst_gnt", 8'(gnt), 8'h00);
      chk("midrst_valid", 8'(valid), 8'h00);
      chk("midrst_sel", 8'(sel), 8'h00);
      tick(4'b1111, 4'b0000, 1'b1);
      chk("postrst_gnt", 8'(gnt), 8'h01);

      // Two steady requesters, then one alone
      tick(4'b0000, 4'b0000, 1'b0);
      for (int k = 1; k <= 20; k++) begin
         tick(4'b0011, 4'($urandom), 1'b1);
         exp_g = (LIMIT && (((k - 1) / HOLD) % 2 == 1)) ? 4'b0010 : 4'b0001;
         chk("pair_gnt", 8'(gnt), 8'(exp_g));
      end
      for (int k = 0; k < 12; k++) begin
         tick(4'b0001, 4'($urandom), 1'b1);
         chk("solo_gnt", 8'(gnt), 8'h01);
      end

      // Random traffic: requests toggle sparsely, occasional reset
      r_rand = 4'b0000;
      for (int k = 0; k < 3000; k++) begin
         r_rand = r_rand ^ (4'($urandom) & 4'($urandom) & 4'($urandom));
         tick(r_rand, 4'($urandom), ($urandom_range(0, 99) != 0));
      end

      cmp_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
